pipe_hazard_ctrl: RTL and testbench

- Pipeline controller for the 5-stage MIPS datapath.
- Decodes the ID-stage instruction into the 9-bit `control` word.
- Tracks in-flight destination registers in a 3-entry scoreboard (EX/MEM/WB).
- Inserts bubbles for RAW hazards and freezes fetch while a `beq` is unresolved.
- Sits between IF/ID and the datapath's `control` input; drives PC and IF/ID enables.

---
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the IF/ID register, the datapath and the hazard controller.
//   master : drives the IF/ID instruction fields and the branch resolution
//            pulse, and observes the controller outputs.
//   slave  : the controller itself.
// Signals:
//   id_valid, opcode, funct, rs, rt, rd  IF/ID instruction fields
//   br_resolve, br_taken                 beq outcome from the MEM stage
//   control                              9-bit control word for ID/EX
//   pc_write, if_id_write, if_id_flush   fetch-side enables
//   fwd_a, fwd_b                         forwarding selects (0 rf, 1 EX/MEM, 2 MEM/WB)
//   illegal, br_timeout                  status pulses
//   stall_cnt                            saturating bubble counter
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int PERF_W = 16
);
  logic              id_valid;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic              br_resolve;
  logic              br_taken;
  logic [8:0]        control;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              illegal;
  logic              br_timeout;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output id_valid, opcode, funct, rs, rt, rd, br_resolve, br_taken,
    input  control, pc_write, if_id_write, if_id_flush, fwd_a, fwd_b,
           illegal, br_timeout, stall_cnt
  );

  modport slave (
    input  id_valid, opcode, funct, rs, rt, rd, br_resolve, br_taken,
    output control, pc_write, if_id_write, if_id_flush, fwd_a, fwd_b,
           illegal, br_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline controller for a 5-stage MIPS datapath. Decodes the ID-stage
// instruction into the control word, tracks in-flight destinations in a
// 3-entry scoreboard (EX/MEM/WB), inserts bubbles on RAW hazards and freezes
// fetch while a beq is unresolved.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    pipe_hazard_ctrl_if.slave (instruction fields in, enables out)
// Parameters:
//   BR_TIMEOUT  BR_WAIT cycles before a forced not-taken exit
//   PERF_W      width of the saturating stall counter
// Build option:
//   PIPE_HAZARD_CTRL_FWD_EN  enables forwarding selects; only load-use stalls.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int BR_TIMEOUT = 4,
  parameter int PERF_W     = 16
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int TMR_W = $clog2(BR_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [8:0] CTL_RTYPE = 9'b1_0_0_1_0_0_0_00;
  localparam logic [8:0] CTL_LW    = 9'b0_1_1_1_1_0_0_01;
  localparam logic [8:0] CTL_SW    = 9'b0_1_0_0_0_1_0_10;
  localparam logic [8:0] CTL_BEQ   = 9'b0_0_0_0_0_0_1_11;

  typedef enum logic [0:0] {RUN, BR_WAIT} state_t;

  typedef struct packed {
    logic       v;
    logic       wr;
    logic       mr;
    logic [4:0] dest;
  } sb_entry_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [PERF_W-1:0] stall_q, stall_d;
  sb_entry_t         sb_ex_q, sb_ex_d;
  sb_entry_t         sb_mem_q, sb_mem_d;
  sb_entry_t         sb_wb_q, sb_wb_d;

  logic [8:0] ctl_dec;
  logic       illegal_dec;
  logic       use_rs, use_rt;
  logic [4:0] dest_dec;
  logic       raw;

  logic [8:0] control;
  logic       pc_write, if_id_write, if_id_flush, br_to, issue, illegal;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic is_writer(input sb_entry_t e);
    return e.v && e.wr && (e.dest != 5'd0);
  endfunction

  function automatic logic src_hit(input sb_entry_t e, input logic use_src,
                                   input logic [4:0] r);
    return use_src && is_writer(e) && (e.dest == r);
  endfunction

  // Select is evaluated in ID for the cycle the instruction sits in EX: the
  // current EX entry will then be in EX/MEM, the current MEM entry in MEM/WB.
  function automatic logic [1:0] fwd_sel(input sb_entry_t ex, input sb_entry_t mem,
                                         input logic use_src, input logic [4:0] r);
    if (src_hit(ex, use_src, r))  return 2'd1;
    if (src_hit(mem, use_src, r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] c);
    return (&c) ? c : c + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    ctl_dec     = '0;
    illegal_dec = 1'b0;
    use_rs      = 1'b0;
    use_rt      = 1'b0;
    dest_dec    = '0;
    if (bus.id_valid) begin
      case (bus.opcode)
        OP_RTYPE: begin ctl_dec = CTL_RTYPE; use_rs = 1'b1; use_rt = 1'b1; dest_dec = bus.rd; end
        OP_LW:    begin ctl_dec = CTL_LW;    use_rs = 1'b1;                dest_dec = bus.rt; end
        OP_SW:    begin ctl_dec = CTL_SW;    use_rs = 1'b1; use_rt = 1'b1; end
        OP_BEQ:   begin ctl_dec = CTL_BEQ;   use_rs = 1'b1; use_rt = 1'b1; end
        default:  illegal_dec = 1'b1;
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign raw = sb_ex_q.mr &&
               (src_hit(sb_ex_q, use_rs, bus.rs) || src_hit(sb_ex_q, use_rt, bus.rt));
`else
  // WB writes the register file before ID reads it, so only EX/MEM conflict.
  assign raw = src_hit(sb_ex_q,  use_rs, bus.rs) || src_hit(sb_ex_q,  use_rt, bus.rt) ||
               src_hit(sb_mem_q, use_rs, bus.rs) || src_hit(sb_mem_q, use_rt, bus.rt);
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stall_d     = stall_q;
    sb_ex_d     = '0;
    sb_mem_d    = sb_ex_q;
    sb_wb_d     = sb_mem_q;
    control     = '0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    br_to       = 1'b0;
    issue       = 1'b0;
    fwd_a       = 2'd0;
    fwd_b       = 2'd0;

    case (state_q)
      RUN: begin
        if (raw) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          stall_d     = sat_inc(stall_q);
        end else begin
          control = ctl_dec;
          issue   = bus.id_valid && !illegal_dec;
`ifdef PIPE_HAZARD_CTRL_FWD_EN
          if (issue) begin
            fwd_a = fwd_sel(sb_ex_q, sb_mem_q, use_rs, bus.rs);
            fwd_b = fwd_sel(sb_ex_q, sb_mem_q, use_rt, bus.rt);
          end
`endif
          if (issue && bus.opcode == OP_BEQ) begin
            state_d = BR_WAIT;
            timer_d = TMR_W'(BR_TIMEOUT);
          end
        end
      end
      default: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        stall_d     = sat_inc(stall_q);
        timer_d     = timer_q - TMR_W'(1);
        if (bus.br_resolve) begin
          state_d  = RUN;
          pc_write = 1'b1;
          if (bus.br_taken) if_id_flush = 1'b1;
          else              if_id_write = 1'b1;
        end else if (timer_q == TMR_W'(1)) begin
          // Timer reaches zero this cycle: report and fall through as not-taken.
          state_d     = RUN;
          br_to       = 1'b1;
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
    endcase

    if (issue) sb_ex_d = '{v: 1'b1, wr: ctl_dec[5], mr: ctl_dec[4], dest: dest_dec};

    illegal = illegal_dec;
    if (reset) begin
      control     = '0;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      fwd_a       = 2'd0;
      fwd_b       = 2'd0;
      illegal     = 1'b0;
      br_to       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      timer_q  <= '0;
      stall_q  <= '0;
      sb_ex_q  <= '0;
      sb_mem_q <= '0;
      sb_wb_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      stall_q  <= stall_d;
      sb_ex_q  <= sb_ex_d;
      sb_mem_q <= sb_mem_d;
      sb_wb_q  <= sb_wb_d;
    end
  end

  assign bus.control     = control;
  assign bus.pc_write    = pc_write;
  assign bus.if_id_write = if_id_write;
  assign bus.if_id_flush = if_id_flush;
  assign bus.fwd_a       = fwd_a;
  assign bus.fwd_b       = fwd_b;
  assign bus.illegal     = illegal;
  assign bus.br_timeout  = br_to;
  assign bus.stall_cnt   = stall_q;

  // funct and some scoreboard fields are carried for the datapath's benefit
  // but not consulted by every build of the stall logic.
  logic sb_unused;
  assign sb_unused = ^{bus.funct, sb_ex_q, sb_mem_q, sb_wb_q};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ILL = 6'h3F;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_pass;
  int   n_total;
  int   exp_stall;

  pipe_hazard_ctrl_if #(.PERF_W(16)) bus ();

  pipe_hazard_ctrl #(.BR_TIMEOUT(4), .PERF_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d);
    bus.id_valid = v;
    bus.opcode   = op;
    bus.funct    = (op == OP_R) ? 6'h20 : 6'h00;
    bus.rs       = s;
    bus.rt       = t;
    bus.rd       = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    repeat (n) tick();
  endtask

  initial begin
    n_pass = 0; n_total = 0; exp_stall = 0;
    bus.br_resolve = 1'b0;
    bus.br_taken   = 1'b0;

    // Reset held 3 cycles with an illegal opcode on the inputs
    drive(1'b1, OP_ILL, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 3; i++) begin
      check("rst_control", 32'(bus.control), 32'h0);
      check("rst_pc_write", 32'(bus.pc_write), 32'd0);
      check("rst_if_id_write", 32'(bus.if_id_write), 32'd0);
      check("rst_flush", 32'(bus.if_id_flush), 32'd1);
      check("rst_illegal", 32'(bus.illegal), 32'd0);
      check("rst_br_timeout", 32'(bus.br_timeout), 32'd0);
      tick();
    end
    reset = 1'b0;

    // add $10,$8,$9 in the first cycle after reset
    drive(1'b1, OP_R, 5'd8, 5'd9, 5'd10);
    check("add_control", 32'(bus.control), 32'h120);
    check("add_pc_write", 32'(bus.pc_write), 32'd1);
    check("add_if_id_write", 32'(bus.if_id_write), 32'd1);
    check("add_flush", 32'(bus.if_id_flush), 32'd0);
    check("add_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    tick();

    // sub $11,$10,$9 depends on the add
    drive(1'b1, OP_R, 5'd10, 5'd9, 5'd11);
`ifdef PIPE_HAZARD_CTRL_FWD_EN
    check("sub_control", 32'(bus.control), 32'h120);
    check("sub_fwd_a", 32'(bus.fwd_a), 32'd1);
    check("sub_fwd_b", 32'(bus.fwd_b), 32'd0);
`else
    check("sub_bubble1_ctl", 32'(bus.control), 32'h0);
    check("sub_bubble1_pc", 32'(bus.pc_write), 32'd0);
    tick();
    check("sub_bubble2_ctl", 32'(bus.control), 32'h0);
    check("sub_bubble2_ifid", 32'(bus.if_id_write), 32'd0);
    tick();
    check("sub_control", 32'(bus.control), 32'h120);
    check("sub_fwd_a", 32'(bus.fwd_a), 32'd0);
    exp_stall += 2;
`endif
    check("sub_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
    tick();
    idle(3);

    // lw $10,0($8) then add $11,$10,$9
    drive(1'b1, OP_LW, 5'd8, 5'd10, 5'd0);
    check("lw_control", 32'(bus.control), 32'h0F1);
    tick();
    drive(1'b1, OP_R, 5'd10, 5'd9, 5'd11);
    check("lu_bubble1_ctl", 32'(bus.control), 32'h0);
    check("lu_bubble1_pc", 32'(bus.pc_write), 32'd0);
    tick();
`ifdef PIPE_HAZARD_CTRL_FWD_EN
    check("lu_control", 32'(bus.control), 32'h120);
    check("lu_fwd_a", 32'(bus.fwd_a), 32'd2);
    exp_stall += 1;
`else
    check("lu_bubble2_ctl", 32'(bus.control), 32'h0);
    tick();
    check("lu_control", 32'(bus.control), 32'h120);
    check("lu_fwd_a", 32'(bus.fwd_a), 32'd0);
    exp_stall += 2;
`endif
    check("lu_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
    tick();
    idle(3);

    // Write to $0 never stalls a reader of $0
    drive(1'b1, OP_R, 5'd8, 5'd9, 5'd0);
    tick();
    drive(1'b1, OP_R, 5'd0, 5'd9, 5'd11);
    check("zero_control", 32'(bus.control), 32'h120);
    check("zero_pc_write", 32'(bus.pc_write), 32'd1);
    tick();
    // lw reads only rs: its rt matching an in-flight dest is not a hazard
    drive(1'b1, OP_R, 5'd8, 5'd9, 5'd5);
    tick();
    drive(1'b1, OP_LW, 5'd9, 5'd5, 5'd0);
    check("lw_rt_control", 32'(bus.control), 32'h0F1);
    check("lw_rt_pc_write", 32'(bus.pc_write), 32'd1);
    tick();
    // Unknown opcode: illegal, control 0, no stall
    drive(1'b1, OP_ILL, 5'd5, 5'd5, 5'd5);
    check("ill_flag", 32'(bus.illegal), 32'd1);
    check("ill_control", 32'(bus.control), 32'h0);
    check("ill_pc_write", 32'(bus.pc_write), 32'd1);
    check("ill_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
    tick();
    idle(3);

    // add $1 then beq $1,$2 (hazard wins), then taken resolve in MEM
    drive(1'b1, OP_R, 5'd8, 5'd9, 5'd1);
    tick();
    drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0);
`ifdef PIPE_HAZARD_CTRL_FWD_EN
    check("beq_control", 32'(bus.control), 32'h007);
    check("beq_fwd_a", 32'(bus.fwd_a), 32'd1);
`else
    check("beq_haz_ctl", 32'(bus.control), 32'h0);
    tick();
    check("beq_haz2_ctl", 32'(bus.control), 32'h0);
    tick();
    check("beq_control", 32'(bus.control), 32'h007);
    exp_stall += 2;
`endif
    tick();
    drive(1'b1, OP_R, 5'd4, 5'd5, 5'd3);
    check("bw_control", 32'(bus.control), 32'h0);
    check("bw_pc_write", 32'(bus.pc_write), 32'd0);
    check("bw_if_id_write", 32'(bus.if_id_write), 32'd0);
    tick();
    bus.br_resolve = 1'b1;
    bus.br_taken   = 1'b1;
    #1;
    check("taken_flush", 32'(bus.if_id_flush), 32'd1);
    check("taken_pc_write", 32'(bus.pc_write), 32'd1);
    check("taken_control", 32'(bus.control), 32'h0);
    tick();
    bus.br_resolve = 1'b0;
    bus.br_taken   = 1'b0;
    #1;
    exp_stall += 2;
    check("taken_run_ctl", 32'(bus.control), 32'h120);
    check("taken_run_flush", 32'(bus.if_id_flush), 32'd0);
    check("taken_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
    tick();
    idle(3);

    // beq with no resolve: timeout on the 4th BR_WAIT cycle
    drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0);
    check("to_beq_control", 32'(bus.control), 32'h007);
    tick();
    drive(1'b1, OP_R, 5'd4, 5'd5, 5'd3);
    for (int i = 1; i <= 3; i++) begin
      check("to_wait_pulse", 32'(bus.br_timeout), 32'd0);
      check("to_wait_pc", 32'(bus.pc_write), 32'd0);
      tick();
    end
    check("to_pulse", 32'(bus.br_timeout), 32'd1);
    check("to_pc_write", 32'(bus.pc_write), 32'd1);
    check("to_if_id_write", 32'(bus.if_id_write), 32'd1);
    tick();
    exp_stall += 4;
    check("to_pulse_end", 32'(bus.br_timeout), 32'd0);
    check("to_held_issue", 32'(bus.control), 32'h120);
    check("to_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
    tick();
    idle(3);

    // Reset in the middle of BR_WAIT aborts without a timeout pulse
    drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rbw_flush", 32'(bus.if_id_flush), 32'd1);
    check("rbw_pulse", 32'(bus.br_timeout), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rbw_pulse_hold", 32'(bus.br_timeout), 32'd0);
    end
    reset = 1'b0;
    drive(1'b1, OP_R, 5'd8, 5'd9, 5'd10);
    check("rbw_pc_write", 32'(bus.pc_write), 32'd1);
    check("rbw_control", 32'(bus.control), 32'h120);
    check("rbw_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
